ring_osc_meas_ctrl: RTL and testbench
=====================================

Name: ring_osc_meas_ctrl

Overview:
Measurement controller for the on-chip ring oscillator bank. It enables one ring at a time and lets it settle. It then counts the rising edges of that ring's divided output over a programmable gate window of `clk` cycles and reports one count per ring. It supports a single sweep or a continuous round-robin scan across a mask of rings. Only one ring runs at a time, which limits supply noise and coupling between rings.

Parameters:
- NUM_OSC, 4, number of ring oscillators in the bank (1..8)
- GATE_W, 16, width of the gate-length input
- CNT_W, 16, width of the edge count
- SETTLE_CYC, 16, `clk` cycles between enabling a ring and opening the gate (≥3)

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a sweep; sampled in IDLE only
- continuous  in  1  1 = restart the sweep after it completes
- osc_mask  in  NUM_OSC  rings included in the sweep; latched at each sweep start
- gate_len  in  GATE_W  gate window in `clk` cycles; latched at each sweep start; 0 is treated as 1
- osc_div_in  in  NUM_OSC  divided ring outputs; asynchronous to `clk`; frequency < clk/4
- osc_en  out  NUM_OSC  one-hot enable to the rings
- busy  out  1  high whenever the state is not IDLE
- result_valid  out  1  one-cycle pulse when a new result is presented
- result_id  out  max(1,$clog2(NUM_OSC))  index of the measured ring
- result_count  out  CNT_W  rising edges counted in the gate window
- result_ovf  out  1  the count saturated

Behaviour:
- Reset (`rst_n` = 0 at a `clk` edge):
  - state = IDLE.
  - All outputs = 0, including the `result_*` registers.
  - Pointer = 0; synchronizer flops = 0.
  - Applies at once even mid-measurement; the ring is disabled on the next cycle.
- FSM states: IDLE, SELECT, SETTLE, MEASURE, REPORT.
- IDLE:
  - `start` = 1 and `osc_mask` ≠ 0: latch mask and gate, set pointer = 0, go to SELECT.
  - `start` with `osc_mask` = 0: ignored.
  - `start` in any other state: ignored.
- SELECT (1 cycle):
  - Choose the lowest set bit of the latched mask at index ≥ pointer.
  - Drive `osc_en` one-hot for that ring from the next cycle.
  - Go to SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles.
  - The input mux selects the chosen ring; the synchronizer fills, but edges are not counted.
  - The edge counter is cleared.
- MEASURE:
  - Lasts exactly G cycles, where G = latched gate_len, or 1 if it is 0.
  - On each cycle with a detected rising edge, count += 1.
  - At all-ones the count holds and the overflow flag is set.
- REPORT (1 cycle):
  - `osc_en` = 0.
  - `result_id`, `result_count` and `result_ovf` are registered; `result_valid` = 1.
  - Results hold until the next REPORT.
  - Exit conditions:
    - Any masked ring remains with index > the current one: pointer = current + 1, go to SELECT.
    - Otherwise, if `continuous` = 1: relatch mask and gate, pointer = 0, go to SELECT. If the relatched mask = 0, go to IDLE.
    - Otherwise: IDLE.
- `continuous` is sampled only in REPORT. Dropping it mid-sweep finishes the current sweep.
- `osc_en` is high only in SETTLE and MEASURE, and never for more than one ring.
- Edge detection:
  - Path: mux(`osc_div_in`, selected index) → 2-flop synchronizer → delay flop.
  - edge = s2 & ~s3.
  - The mux selection changes only in SELECT, and the flush happens in SETTLE.
- Timing: `start` sampled at edge k gives:
  - SELECT at k+1.
  - `osc_en` high at k+2 through k+1+SETTLE_CYC+G.
  - `result_valid` at k+2+SETTLE_CYC+G.
- Edges closer together than 2 `clk` cycles may be missed; the input rate is specified below clk/4.

Decomposition:
- Package ring_osc_pkg:
  - FSM state enum.
  - Default parameter constants.
  - A function for the index width.
- Sub-module sync_edge_det (2-flop synchronizer plus rising-edge pulse), one instance after the input mux.
- All other logic stays in the top module.

Test Plan:
- Single ring: `osc_mask` = 4'b0001, ring 0 period 10 `clk`, `gate_len` = 100, `start` pulse. Required: one `result_valid` with id = 0, count = 10 (±1), ovf = 0; `busy` falls; `result_valid` at k+2+16+100.
- Sparse mask sweep: `osc_mask` = 4'b1010, ring 1 period 8, ring 3 period 20, gate 200. Required: results id = 1 count 25 (±1), then id = 3 count 10 (±1); `osc_en` = 0010 then 1000; never two bits set.
- Overflow: CNT_W = 4, period 4, gate 100. Required: count = 15, ovf = 1.
- Continuous scan: mask = 4'b0011, `continuous` = 1 for three sweeps, then dropped mid-sweep. Required: ids follow 0,1,0,1,0,1 and the sweep in progress completes; then IDLE.
- Edge cases:
  - `gate_len` = 0 behaves as 1.
  - `start` with mask 0 is ignored.
  - `start` while `busy` is ignored.
  - `rst_n` low in MEASURE: all outputs 0 on the next cycle, IDLE, no `result_valid`.
- Settle masking: ring toggling only during SETTLE, quiet in MEASURE. Required: count = 0.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared types and defaults for the ring oscillator measurement controller.
package ring_osc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_MEASURE,
      ST_REPORT
   } state_t;

   localparam int DEF_NUM_OSC    = 4;
   localparam int DEF_GATE_W     = 16;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_SETTLE_CYC = 16;

   // Width of a ring index; a single-ring bank still gets a 1-bit id.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the selected divided ring output, plus a delay
// flop that turns a synchronized low-to-high transition into a one-cycle pulse.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Sequences the ring oscillator bank one ring at a time: select, settle,
// count divided-output edges over a gate window, then report the count.
module ring_osc_meas_ctrl
   import ring_osc_pkg::*;
#(
   parameter int NUM_OSC    = DEF_NUM_OSC,
   parameter int GATE_W     = DEF_GATE_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        continuous,
   input  logic [NUM_OSC-1:0]          osc_mask,
   input  logic [GATE_W-1:0]           gate_len,
   input  logic [NUM_OSC-1:0]          osc_div_in,
   output logic [NUM_OSC-1:0]          osc_en,
   output logic                        busy,
   output logic                        result_valid,
   output logic [idx_w(NUM_OSC)-1:0]   result_id,
   output logic [CNT_W-1:0]            result_count,
   output logic                        result_ovf
);

   localparam int ID_W  = idx_w(NUM_OSC);
   localparam int SET_W = $clog2(SETTLE_CYC);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               state;
   logic [NUM_OSC-1:0]   mask_q;
   logic [GATE_W-1:0]    gate_q;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      sel_idx;
   logic [ID_W-1:0]      pick;
   logic [TMR_W-1:0]     tmr;
   logic [TMR_W-1:0]     gate_last;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 ovf;
   logic                 ovf_nxt;
   logic                 more_after;
   logic                 osc_mux;
   logic                 rise;

   // Lowest masked ring at or above the pointer; SELECT is only entered when one exists.
   always_comb begin
      pick = '0;
      for (int i = NUM_OSC - 1; i >= 0; i--) begin
         if (mask_q[i] && (i >= int'(ptr))) pick = ID_W'(i);
      end
   end

   always_comb begin
      more_after = 1'b0;
      for (int i = 0; i < NUM_OSC; i++) begin
         if (mask_q[i] && (i > int'(sel_idx))) more_after = 1'b1;
      end
   end

   // The mux select only moves in SELECT, so the settle window flushes stale history.
   assign osc_mux = osc_div_in[sel_idx];

   sync_edge_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (osc_mux),
      .rise  (rise)
   );

   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (rise) begin
         if (cnt == CNT_MAX) ovf_nxt = 1'b1;
         else                cnt_nxt = cnt + 1'b1;
      end
   end

   assign gate_last = (gate_q == '0) ? '0 : TMR_W'(gate_q - 1'b1);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         mask_q       <= '0;
         gate_q       <= '0;
         ptr          <= '0;
         sel_idx      <= '0;
         tmr          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         osc_en       <= '0;
         result_valid <= 1'b0;
         result_id    <= '0;
         result_count <= '0;
         result_ovf   <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && (osc_mask != '0)) begin
                  mask_q <= osc_mask;
                  gate_q <= gate_len;
                  ptr    <= '0;
                  state  <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               sel_idx <= pick;
               osc_en  <= NUM_OSC'(1) << pick;
               tmr     <= TMR_W'(SETTLE_CYC - 1);
               state   <= ST_SETTLE;
            end
            ST_SETTLE: begin
               cnt <= '0;
               ovf <= 1'b0;
               if (tmr == '0) begin
                  tmr   <= gate_last;
                  state <= ST_MEASURE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_MEASURE: begin
               cnt <= cnt_nxt;
               ovf <= ovf_nxt;
               if (tmr == '0) begin
                  osc_en       <= '0;
                  result_valid <= 1'b1;
                  result_id    <= sel_idx;
                  result_count <= cnt_nxt;
                  result_ovf   <= ovf_nxt;
                  state        <= ST_REPORT;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_REPORT: begin
               if (more_after) begin
                  ptr   <= sel_idx + 1'b1;
                  state <= ST_SELECT;
               end else if (continuous) begin
                  mask_q <= osc_mask;
                  gate_q <= gate_len;
                  ptr    <= '0;
                  state  <= (osc_mask != '0) ? ST_SELECT : ST_IDLE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl: a behavioural ring bank, a result monitor and
// scenario tasks that compare monitored results against an expected queue.
module tb_ring_osc_meas_ctrl;

   localparam int NUM_OSC = 4;
   localparam int GATE_W  = 16;
   localparam int CNT_W   = 16;
   localparam int SETTLE  = 16;
   localparam int ID_W    = 2;
   localparam int EXP_W   = 1 + ID_W + CNT_W;
   localparam int OBS2_W  = 1 + ID_W + 4;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic               start_ovf;
   logic               continuous;
   logic [NUM_OSC-1:0] osc_mask;
   logic [GATE_W-1:0]  gate_len;
   logic [NUM_OSC-1:0] osc_div;

   logic [NUM_OSC-1:0] osc_en;
   logic               busy;
   logic               result_valid;
   logic [ID_W-1:0]    result_id;
   logic [CNT_W-1:0]   result_count;
   logic               result_ovf;

   logic [NUM_OSC-1:0] osc_en_b;
   logic               busy_b;
   logic               result_valid_b;
   logic [ID_W-1:0]    result_id_b;
   logic [3:0]         result_count_b;
   logic               result_ovf_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int onehot_viol = 0;
   int period[NUM_OSC];
   int ph[NUM_OSC];

   logic [EXP_W-1:0]   exp_q[$];
   logic [EXP_W-1:0]   obs_q[$];
   int                 obs_at_q[$];
   logic [NUM_OSC-1:0] en_q[$];
   logic [OBS2_W-1:0]  obs2_q[$];
   logic [NUM_OSC-1:0] last_en;

   ring_osc_meas_ctrl #(
      .NUM_OSC(NUM_OSC), .GATE_W(GATE_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
      .osc_mask(osc_mask), .gate_len(gate_len), .osc_div_in(osc_div),
      .osc_en(osc_en), .busy(busy), .result_valid(result_valid),
      .result_id(result_id), .result_count(result_count), .result_ovf(result_ovf)
   );

   ring_osc_meas_ctrl #(
      .NUM_OSC(NUM_OSC), .GATE_W(GATE_W), .CNT_W(4), .SETTLE_CYC(SETTLE)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start_ovf), .continuous(1'b0),
      .osc_mask(osc_mask), .gate_len(gate_len), .osc_div_in(osc_div),
      .osc_en(osc_en_b), .busy(busy_b), .result_valid(result_valid_b),
      .result_id(result_id_b), .result_count(result_count_b), .result_ovf(result_ovf_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- ring bank model ----------------
   initial begin
      osc_div = '0;
      for (int i = 0; i < NUM_OSC; i++) begin
         period[i] = 0;
         ph[i] = 0;
      end
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_OSC; i++) begin
            if (period[i] > 1) begin
               ph[i]++;
               if (ph[i] >= period[i] / 2) begin
                  ph[i] = 0;
                  osc_div[i] = ~osc_div[i];
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      last_en = '0;
      forever begin
         @(negedge clk);
         if (result_valid) begin
            obs_q.push_back({result_ovf, result_id, result_count});
            obs_at_q.push_back(cyc + 1);
         end
         if (result_valid_b) obs2_q.push_back({result_ovf_b, result_id_b, result_count_b});
         if ($countones(osc_en) > 1) onehot_viol++;
         if (osc_en != '0 && osc_en != last_en) en_q.push_back(osc_en);
         last_en = osc_en;
      end
   end

   // ---------------- drivers ----------------
   task automatic pulse_start(input logic [NUM_OSC-1:0] m, input logic [GATE_W-1:0] g,
                              output int k);
      @(negedge clk);
      osc_mask = m;
      gate_len = g;
      start = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic set_period(input int i, input int p);
      period[i] = p;
      ph[i] = 0;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      obs_q.delete();
      obs_at_q.delete();
      en_q.delete();
      obs2_q.delete();
      onehot_viol = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start_ovf = 1'b0; continuous = 1'b0;
      osc_mask = '0; gate_len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({osc_en, busy, result_valid} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: osc_en=%b busy=%b valid=%b, need all 0", osc_en, busy, result_valid);
      end
      checks++;
      if ({result_id, result_count, result_ovf} !== '0) begin
         errors++;
         $display("FAIL reset_result: id=%0d count=%0d ovf=%b, need 0", result_id, result_count, result_ovf);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int k;
      logic [EXP_W-1:0] e, o;
      clear_sb();
      set_period(0, 10);
      exp_q.push_back({1'b0, 2'd0, 16'd10});
      pulse_start(4'b0001, 16'd100, k);
      for (int t = 0; t < 400 && obs_q.size() < 1; t++) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL single_count_results: got %0d results, need 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o[EXP_W-2 -: ID_W] !== e[EXP_W-2 -: ID_W] || o[EXP_W-1] !== e[EXP_W-1]) begin
            errors++;
            $display("FAIL single_id_ovf: got id=%0d ovf=%b, need id=%0d ovf=%b",
                     o[EXP_W-2 -: ID_W], o[EXP_W-1], e[EXP_W-2 -: ID_W], e[EXP_W-1]);
         end
         checks++;
         if (int'(o[CNT_W-1:0]) < int'(e[CNT_W-1:0]) - 1 || int'(o[CNT_W-1:0]) > int'(e[CNT_W-1:0]) + 1) begin
            errors++;
            $display("FAIL single_count: got %0d, need %0d +-1", o[CNT_W-1:0], e[CNT_W-1:0]);
         end
         checks++;
         if (obs_at_q.pop_front() != k + 2 + SETTLE + 100) begin
            errors++;
            $display("FAIL single_latency: result not at edge %0d", k + 2 + SETTLE + 100);
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || en_q.size() != 1 || en_q[0] !== 4'b0001) begin
         errors++;
         $display("FAIL single_idle_en: busy=%b en_seen=%0d, need busy 0 and one enable 0001", busy, en_q.size());
      end
   endtask

   task automatic test_sparse();
      int k;
      logic [EXP_W-1:0] e, o;
      clear_sb();
      set_period(0, 0);
      set_period(1, 8);
      set_period(3, 20);
      exp_q.push_back({1'b0, 2'd1, 16'd25});
      exp_q.push_back({1'b0, 2'd3, 16'd10});
      pulse_start(4'b1010, 16'd200, k);
      for (int t = 0; t < 800 && obs_q.size() < 2; t++) @(negedge clk);
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL sparse_count_results: got %0d results, need 2", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o[EXP_W-2 -: ID_W] !== e[EXP_W-2 -: ID_W] || o[EXP_W-1] !== 1'b0) begin
            errors++;
            $display("FAIL sparse_id: got id=%0d ovf=%b, need id=%0d ovf=0",
                     o[EXP_W-2 -: ID_W], o[EXP_W-1], e[EXP_W-2 -: ID_W]);
         end
         checks++;
         if (int'(o[CNT_W-1:0]) < int'(e[CNT_W-1:0]) - 1 || int'(o[CNT_W-1:0]) > int'(e[CNT_W-1:0]) + 1) begin
            errors++;
            $display("FAIL sparse_count: got %0d, need %0d +-1", o[CNT_W-1:0], e[CNT_W-1:0]);
         end
      end
      checks++;
      if (en_q.size() != 2 || en_q[0] !== 4'b0010 || en_q[1] !== 4'b1000) begin
         errors++;
         $display("FAIL sparse_enables: saw %0d enables, need 0010 then 1000", en_q.size());
      end
      checks++;
      if (onehot_viol != 0) begin
         errors++;
         $display("FAIL sparse_onehot: %0d cycles with >1 enable, need 0", onehot_viol);
      end
      set_period(1, 0);
      set_period(3, 0);
   endtask

   task automatic test_overflow();
      logic [OBS2_W-1:0] o;
      clear_sb();
      set_period(0, 4);
      @(negedge clk);
      osc_mask = 4'b0001;
      gate_len = 16'd100;
      start_ovf = 1'b1;
      @(negedge clk);
      start_ovf = 1'b0;
      for (int t = 0; t < 400 && obs2_q.size() < 1; t++) @(negedge clk);
      checks++;
      if (obs2_q.size() != 1) begin
         errors++;
         $display("FAIL ovf_results: got %0d results, need 1", obs2_q.size());
      end else begin
         o = obs2_q.pop_front();
         checks++;
         if (o[3:0] !== 4'd15 || o[OBS2_W-1] !== 1'b1 || o[5:4] !== 2'd0) begin
            errors++;
            $display("FAIL ovf_saturate: got count=%0d ovf=%b id=%0d, need 15 1 0", o[3:0], o[OBS2_W-1], o[5:4]);
         end
      end
      set_period(0, 0);
   endtask

   task automatic test_continuous();
      int k;
      logic [EXP_W-1:0] e, o;
      clear_sb();
      set_period(0, 10);
      set_period(1, 10);
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, ID_W'(i % 2), 16'd2});
      continuous = 1'b1;
      pulse_start(4'b0011, 16'd20, k);
      for (int t = 0; t < 1000 && obs_q.size() < 5; t++) @(negedge clk);
      continuous = 1'b0;
      for (int t = 0; t < 500 && obs_q.size() < 6; t++) @(negedge clk);
      repeat (200) @(negedge clk);
      checks++;
      if (obs_q.size() != 6 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop: got %0d results busy=%b, need 6 results and idle", obs_q.size(), busy);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o[EXP_W-2 -: ID_W] !== e[EXP_W-2 -: ID_W] ||
             int'(o[CNT_W-1:0]) > int'(e[CNT_W-1:0]) + 1 || int'(o[CNT_W-1:0]) < int'(e[CNT_W-1:0]) - 1) begin
            errors++;
            $display("FAIL cont_order: got id=%0d count=%0d, need id=%0d count %0d +-1",
                     o[EXP_W-2 -: ID_W], o[CNT_W-1:0], e[EXP_W-2 -: ID_W], e[CNT_W-1:0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      clear_sb();
      pulse_start(4'b0001, 16'd200, k);
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || osc_en !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_pre: busy=%b osc_en=%b, need 1 and 0001", busy, osc_en);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({osc_en, busy, result_valid, result_id, result_count, result_ovf} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear: osc_en=%b busy=%b valid=%b id=%0d count=%0d ovf=%b, need all 0",
                  osc_en, busy, result_valid, result_id, result_count, result_ovf);
      end
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_result: got %0d results busy=%b, need 0 and idle", obs_q.size(), busy);
      end
      set_period(0, 0);
      set_period(1, 0);
   endtask

   task automatic test_gate_zero();
      int k;
      logic [EXP_W-1:0] o;
      clear_sb();
      pulse_start(4'b0100, 16'd0, k);
      for (int t = 0; t < 100 && obs_q.size() < 1; t++) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL gate0_results: got %0d results, need 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (obs_at_q.pop_front() != k + 2 + SETTLE + 1 || o[EXP_W-2 -: ID_W] !== 2'd2 || o[CNT_W-1:0] !== '0) begin
            errors++;
            $display("FAIL gate0_window: id=%0d count=%0d, need id 2 count 0 at edge %0d",
                     o[EXP_W-2 -: ID_W], o[CNT_W-1:0], k + 2 + SETTLE + 1);
         end
      end
   endtask

   task automatic test_mask_zero();
      int k;
      int busy_seen;
      clear_sb();
      busy_seen = 0;
      pulse_start(4'b0000, 16'd20, k);
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      checks++;
      if (busy_seen != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL mask0_ignored: busy cycles=%0d results=%0d, need 0 0", busy_seen, obs_q.size());
      end
   endtask

   task automatic test_start_busy();
      int k;
      logic [EXP_W-1:0] o;
      clear_sb();
      set_period(0, 10);
      pulse_start(4'b0001, 16'd50, k);
      repeat (5) @(negedge clk);
      osc_mask = 4'b0010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      checks++;
      if (obs_q.size() != 1 || busy !== 1'b0 || en_q.size() != 1) begin
         errors++;
         $display("FAIL busy_start_ignored: results=%0d enables=%0d busy=%b, need 1 1 0",
                  obs_q.size(), en_q.size(), busy);
      end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (o[EXP_W-2 -: ID_W] !== 2'd0 || int'(o[CNT_W-1:0]) < 4 || int'(o[CNT_W-1:0]) > 6) begin
            errors++;
            $display("FAIL busy_result: got id=%0d count=%0d, need id 0 count 5 +-1",
                     o[EXP_W-2 -: ID_W], o[CNT_W-1:0]);
         end
      end
      set_period(0, 0);
   endtask

   task automatic test_settle_mask();
      int k;
      logic [EXP_W-1:0] o;
      clear_sb();
      pulse_start(4'b0001, 16'd20, k);
      set_period(0, 4);
      repeat (10) @(negedge clk);
      set_period(0, 0);
      for (int t = 0; t < 100 && obs_q.size() < 1; t++) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL settle_results: got %0d results, need 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o[CNT_W-1:0] !== '0 || o[EXP_W-1] !== 1'b0) begin
            errors++;
            $display("FAIL settle_masked: got count=%0d ovf=%b, need 0 0", o[CNT_W-1:0], o[EXP_W-1]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_sparse();
      test_overflow();
      test_continuous();
      test_reset_mid();
      test_gate_zero();
      test_mask_zero();
      test_start_busy();
      test_settle_mask();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
